// File: rtl/seq_det_sched_if.sv
// Request/response bus between the packet-side requesters and the detector scheduler.
// The master side is the requesters; the slave side is the scheduler.
interface seq_det_sched_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_ready;
    logic             resp_valid;
    logic             resp_id;
    logic [CNT_W-1:0] resp_count;

    modport master (
        output req_valid, req_data0, req_data1,
        input  req_ready, resp_valid, resp_id, resp_count
    );

    modport slave (
        input  req_valid, req_data0, req_data1,
        output req_ready, resp_valid, resp_id, resp_count
    );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial sequence detector between two requesters:
// reset the detector, shift the job word MSB-first, count matches, return the tagged count.
module seq_det_sched #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    seq_det_sched_if.slave    bus,
    output logic              det_din,
    output logic              det_rst,
    input  logic              det_dout,
    output logic              busy
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_RESP} state_t;

    // Bit counter runs across SHIFT and DRAIN so it doubles as the window index.
    localparam int              BCW        = $clog2(WIDTH + DET_LAT + 1);
    localparam logic [BCW-1:0]  LAST_SHIFT = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0]  LAST_DRAIN = BCW'(WIDTH + DET_LAT - 1);
    localparam logic [BCW-1:0]  WIN_START  = BCW'(DET_LAT);

    state_t           r_state, w_next;
    logic             r_last_grant;
    logic             r_id;
    logic             r_det_rst;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_shift;
    logic [BCW-1:0]   r_bitcnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_resp_count;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_ready;
    logic             w_xfer;
    logic             w_xfer_id;
    logic             w_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 2'b00;
        case (r_state)
            S_IDLE: begin
                case (bus.req_valid)
                    2'b01:   w_ready = 2'b01;
                    2'b10:   w_ready = 2'b10;
                    2'b11:   w_ready = r_last_grant ? 2'b01 : 2'b10;
                    default: w_ready = 2'b00;
                endcase
                if (|(bus.req_valid & w_ready)) w_next = S_CLR;
            end
            S_CLR:   w_next = S_SHIFT;
            S_SHIFT: if (r_bitcnt == LAST_SHIFT) w_next = (DET_LAT > 0) ? S_DRAIN : S_RESP;
            S_DRAIN: if (r_bitcnt == LAST_DRAIN) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_xfer     = |(bus.req_valid & w_ready);
    assign w_xfer_id  = w_ready[1];
    assign w_sample   = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) && (r_bitcnt >= WIN_START);
    assign w_cnt_next = (w_sample && det_dout && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_det_rst    <= 1'b1;
            r_resp_id    <= 1'b0;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_cnt        <= '0;
            r_resp_count <= '0;
        end else begin
            r_det_rst <= (w_next == S_CLR);
            if (w_xfer) begin
                r_shift      <= w_xfer_id ? bus.req_data1 : bus.req_data0;
                r_id         <= w_xfer_id;
                r_last_grant <= w_xfer_id;
                r_cnt        <= '0;
                r_bitcnt     <= '0;
            end else begin
                if (r_state == S_SHIFT) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                if ((r_state == S_SHIFT) || (r_state == S_DRAIN)) r_bitcnt <= r_bitcnt + BCW'(1);
                r_cnt <= w_cnt_next;
            end
            // Response registers load with the final window sample and hold until the next job ends.
            if ((w_next == S_RESP) && (r_state != S_RESP)) begin
                r_resp_id    <= r_id;
                r_resp_count <= w_cnt_next;
            end
        end
    end

    assign det_din        = (r_state == S_SHIFT) & r_shift[WIDTH-1];
    assign det_rst        = r_det_rst;
    assign busy           = (r_state != S_IDLE);
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_count = r_resp_count;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with an overlapping "1011" Moore detector model
// on the default instance and a narrow-count, 16-bit instance for saturation.
module tb_seq_det_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_det_sched_if #(.WIDTH(8),  .CNT_W(4)) ifa();
    seq_det_sched_if #(.WIDTH(16), .CNT_W(2)) ifb();

    logic din_a, drst_a, dout_a, busy_a;
    logic din_b, drst_b, dout_b, busy_b;
    logic [2:0] ds_a = 3'd0;
    logic [2:0] ds_b = 3'd0;

    seq_det_sched #(.WIDTH(8), .CNT_W(4), .DET_LAT(1)) u_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .det_din(din_a), .det_rst(drst_a), .det_dout(dout_a), .busy(busy_a)
    );
    seq_det_sched #(.WIDTH(16), .CNT_W(2), .DET_LAT(1)) u_b (
        .clk(clk), .rst(rst), .bus(ifb),
        .det_din(din_b), .det_rst(drst_b), .det_dout(dout_b), .busy(busy_b)
    );

    // Overlapping "1011" detector: state = longest matched prefix, output registered.
    function automatic logic [2:0] det_nxt(input logic [2:0] s, input logic d);
        case (s)
            3'd0:    return d ? 3'd1 : 3'd0;
            3'd1:    return d ? 3'd1 : 3'd2;
            3'd2:    return d ? 3'd3 : 3'd0;
            3'd3:    return d ? 3'd4 : 3'd2;
            default: return d ? 3'd1 : 3'd2;
        endcase
    endfunction

    always @(posedge clk) begin
        ds_a <= drst_a ? 3'd0 : det_nxt(ds_a, din_a);
        ds_b <= drst_b ? 3'd0 : det_nxt(ds_b, din_b);
    end
    assign dout_a = (ds_a == 3'd4);
    assign dout_b = (ds_b == 3'd4);

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int overlap = 0;
    int acc_id[$], acc_cyc[$], rsp_id[$], rsp_cnt[$], rsp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|(ifa.req_valid & ifa.req_ready)) begin
            acc_id.push_back(int'(ifa.req_ready[1]));
            acc_cyc.push_back(cyc);
        end
        if (ifa.resp_valid) begin
            rsp_id.push_back(int'(ifa.resp_id));
            rsp_cnt.push_back(int'(ifa.resp_count));
            rsp_cyc.push_back(cyc);
        end
        if (ifa.resp_valid && (|(ifa.req_valid & ifa.req_ready))) overlap++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic wait_acc(input int n);
        for (int i = 0; i < 100 && acc_id.size() < n; i++) tick();
        chk("acc_wait", acc_id.size(), n);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 100 && rsp_id.size() < n; i++) tick();
        chk("rsp_wait", rsp_id.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifa.req_valid = 2'b00;
        ifb.req_valid = 2'b00;
        tick(3);
        rst = 1'b1;
        tick(2);
        acc_id.delete(); acc_cyc.delete();
        rsp_id.delete(); rsp_cnt.delete(); rsp_cyc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  din_seq;
        logic        rst_seen;
        logic [3:0]  g;
        logic [3:0]  r;
        logic [15:0] c;

        ifa.req_valid = 2'b00; ifa.req_data0 = '0; ifa.req_data1 = '0;
        ifb.req_valid = 2'b00; ifb.req_data0 = '0; ifb.req_data1 = '0;

        // Reset and idle
        tick(2);
        chk("rst_detrst", drst_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", ifa.req_ready, 0);
        chk("rst_rvalid", ifa.resp_valid, 0);
        chk("rst_rid", ifa.resp_id, 0);
        chk("rst_rcnt", ifa.resp_count, 0);
        rst = 1'b1;
        tick();
        chk("idle_detrst", drst_a, 0);
        tick(5);
        chk("idle_busy", busy_a, 0);
        chk("idle_ready", ifa.req_ready, 0);
        chk("idle_nrsp", rsp_id.size(), 0);

        // Single job 0xB6 -> 2 matches
        ifa.req_data0 = 8'hB6;
        ifa.req_valid = 2'b01;
        #1;
        chk("s_ready", ifa.req_ready, 2'b01);
        tick();
        ifa.req_valid = 2'b00;
        chk("clr_detrst", drst_a, 1);
        chk("clr_busy", busy_a, 1);
        chk("clr_ready", ifa.req_ready, 0);
        din_seq = '0; rst_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            din_seq  = {din_seq[6:0], din_a};
            rst_seen = rst_seen | drst_a;
        end
        chk("s_din_seq", din_seq, 8'hB6);
        chk("s_detrst_once", rst_seen, 0);
        wait_rsp(1);
        chk("s_id", qat(rsp_id, 0), 0);
        chk("s_cnt", qat(rsp_cnt, 0), 2);
        chk("s_lat", qat(rsp_cyc, 0) - qat(acc_cyc, 0), 11);
        chk("s_pulse", ifa.resp_valid, 0);
        chk("s_hold", ifa.resp_count, 2);
        chk("s_idle", busy_a, 0);

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        ifa.req_data0 = 8'hBB; ifa.req_data1 = 8'hFF;
        ifa.req_valid = 2'b11;
        #1;
        chk("sim_ready", ifa.req_ready, 2'b01);
        wait_acc(1);
        ifa.req_valid[0] = 1'b0;
        wait_acc(2);
        ifa.req_valid = 2'b00;
        wait_rsp(2);
        chk("sim_g0", qat(acc_id, 0), 0);
        chk("sim_g1", qat(acc_id, 1), 1);
        chk("sim_gap", qat(acc_cyc, 1) - qat(acc_cyc, 0), 12);
        chk("sim_r0", qat(rsp_id, 0) * 16 + qat(rsp_cnt, 0), 32'h02);
        chk("sim_r1", qat(rsp_id, 1) * 16 + qat(rsp_cnt, 1), 32'h10);

        // Request withdrawn while busy never starts a job
        do_reset();
        ifa.req_data0 = 8'hB6;
        ifa.req_valid = 2'b01;
        wait_acc(1);
        ifa.req_valid = 2'b00;
        tick(2);
        ifa.req_valid = 2'b10;
        #1;
        chk("busy_ready", ifa.req_ready, 0);
        tick(3);
        ifa.req_valid = 2'b00;
        wait_rsp(1);
        tick(3);
        chk("drop_noacc", acc_id.size(), 1);

        // Round-robin: both held valid for 4 jobs; 0x0B matches on its last bit (drain sample)
        do_reset();
        ifa.req_data0 = 8'hB6; ifa.req_data1 = 8'h0B;
        ifa.req_valid = 2'b11;
        wait_acc(4);
        ifa.req_valid = 2'b00;
        wait_rsp(4);
        g = '0; r = '0; c = '0;
        for (int i = 0; i < 4; i++) begin
            g = {g[2:0], qat(acc_id, i) == 1};
            r = {r[2:0], qat(rsp_id, i) == 1};
            c = {c[11:0], 4'(qat(rsp_cnt, i))};
        end
        chk("rr_grants", g, 4'b0101);
        chk("rr_rsp_ids", r, 4'b0101);
        chk("rr_counts", c, 16'h2121);

        // Reset in SHIFT cycle 3
        do_reset();
        ifa.req_data0 = 8'hB6;
        ifa.req_valid = 2'b01;
        wait_acc(1);
        ifa.req_valid = 2'b00;
        tick(4);
        rst = 1'b0;
        #1;
        chk("ab_detrst", drst_a, 1);
        chk("ab_busy", busy_a, 0);
        chk("ab_rvalid", ifa.resp_valid, 0);
        tick(2);
        chk("ab_detrst_hold", drst_a, 1);
        rst = 1'b1;
        tick(20);
        chk("ab_norsp", rsp_id.size(), 0);
        ifa.req_data0 = 8'hBB;
        ifa.req_valid = 2'b01;
        wait_acc(2);
        ifa.req_valid = 2'b00;
        wait_rsp(1);
        chk("ab_next_id", qat(rsp_id, 0), 0);
        chk("ab_next_cnt", qat(rsp_cnt, 0), 2);

        // Saturation: 16-bit word with 4 matches on a 2-bit count
        ifb.req_data0 = 16'hBBBB;
        ifb.req_valid = 2'b01;
        tick();
        ifb.req_valid = 2'b00;
        for (int i = 0; i < 60 && !ifb.resp_valid; i++) tick();
        chk("sat_vld", ifb.resp_valid, 1);
        chk("sat_cnt", ifb.resp_count, 3);
        tick(2);
        ifb.req_data0 = 16'h000B;
        ifb.req_valid = 2'b01;
        tick();
        ifb.req_valid = 2'b00;
        for (int i = 0; i < 60 && !ifb.resp_valid; i++) tick();
        chk("w16_vld", ifb.resp_valid, 1);
        chk("w16_cnt", ifb.resp_count, 1);

        chk("no_acc_on_resp", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
